// File: rtl/rf_write_arbiter_pkg.sv
// Shared register-file writeback definitions: default widths, queue depth and the
// arbiter priority encoding.
package rf_write_arbiter_pkg;

  localparam int RF_ADDR_W   = 3;
  localparam int RF_DATA_W   = 16;
  localparam int RF_NUM_REGS = 1 << RF_ADDR_W;
  localparam int RF_DEPTH    = 2;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

endpackage

// File: rtl/wb_fifo.sv
// Small writeback queue: DEPTH entries of W bits with occupancy count.
// Push when full and pop when empty are ignored.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 19
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full && !reset;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Merges execute (A) and load-return (B) writebacks onto the single registered
// RegFile write port with round-robin arbitration and a per-register pending mask.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [ADDR_W-1:0]        a_dr,
  input  logic [DATA_W-1:0]        a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [ADDR_W-1:0]        b_dr,
  input  logic [DATA_W-1:0]        b_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_dr,
  output logic [DATA_W-1:0]        rf_data,
  output logic [(1<<ADDR_W)-1:0]   pending,
  output logic                     busy
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int W        = ADDR_W + DATA_W;
  localparam int CW       = $clog2(DEPTH+1);
  localparam int PCW      = $clog2(2*DEPTH+2);

  logic [W-1:0]  a_dout, b_dout, head;
  logic [CW-1:0] a_count, b_count;
  logic          a_full, a_empty, b_full, b_empty;
  logic          push_a, push_b, grant_a, grant_b;

  prio_e              prio_q;
  logic               rf_we_q;
  logic [ADDR_W-1:0]  rf_dr_q;
  logic [DATA_W-1:0]  rf_data_q;
  logic [PCW-1:0]     pcnt_q [NUM_REGS];
  logic [PCW-1:0]     pcnt_d [NUM_REGS];

  // valid/ready: a source transfers on a posedge where x_valid && x_ready; ready
  // depends only on occupancy (a same-cycle pop never raises it) and is low in reset.
  assign a_ready = !reset && !a_full;
  assign b_ready = !reset && !b_full;
  assign push_a  = a_valid && a_ready;
  assign push_b  = b_valid && b_ready;

  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo_a (
    .clk(clk), .reset(reset), .push(push_a), .din({a_dr, a_data}), .pop(grant_a),
    .dout(a_dout), .count(a_count), .full(a_full), .empty(a_empty)
  );

  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo_b (
    .clk(clk), .reset(reset), .push(push_b), .din({b_dr, b_data}), .pop(grant_b),
    .dout(b_dout), .count(b_count), .full(b_full), .empty(b_empty)
  );

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!a_empty && (b_empty || prio_q == PRIO_A)) grant_a = 1'b1;
    else if (!b_empty)                             grant_b = 1'b1;
  end

  assign head = grant_a ? a_dout : b_dout;

  // rf_dr/rf_data hold their last value on idle cycles; only rf_we qualifies them.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q   <= 1'b0;
      rf_dr_q   <= '0;
      rf_data_q <= '0;
      prio_q    <= PRIO_A;
    end else begin
      rf_we_q <= grant_a || grant_b;
      if (grant_a || grant_b) {rf_dr_q, rf_data_q} <= head;
      if (grant_a)      prio_q <= PRIO_B;
      else if (grant_b) prio_q <= PRIO_A;
    end
  end

  // Count drops at the edge where RegFile commits, so pending clears as soon as
  // the register already holds the value.
  always_comb begin
    pending = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pcnt_d[r] = pcnt_q[r]
                + PCW'(push_a && (a_dr == ADDR_W'(r)))
                + PCW'(push_b && (b_dr == ADDR_W'(r)))
                - PCW'(rf_we_q && (rf_dr_q == ADDR_W'(r)));
      pending[r] = (pcnt_q[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) pcnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) pcnt_q[r] <= pcnt_d[r];
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_dr   = rf_dr_q;
  assign rf_data = rf_data_q;
  assign busy    = (a_count != '0) || (b_count != '0) || rf_we_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, and a RegFile image fed by rf_*.
module tb_rf_write_arbiter;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;
  localparam int W      = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              a_valid = 1'b0, b_valid = 1'b0;
  logic [ADDR_W-1:0] a_dr = '0, b_dr = '0;
  logic [DATA_W-1:0] a_data = '0, b_data = '0;
  logic              a_ready, b_ready, rf_we, busy;
  logic [ADDR_W-1:0] rf_dr;
  logic [DATA_W-1:0] rf_data;
  logic [NREG-1:0]   pending;

  int n_vec  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;
  logic log_en = 1'b0;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_dr(a_dr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dr(b_dr), .b_data(b_data),
    .rf_we(rf_we), .rf_dr(rf_dr), .rf_data(rf_data), .pending(pending), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0]      ma_q[$];
  logic [W-1:0]      mb_q[$];
  logic              m_prio_b = 1'b0;
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_dr = '0;
  logic [DATA_W-1:0] m_data = '0;

  always @(posedge clk) begin : model
    logic acc_a, acc_b;
    logic [W-1:0] h;
    acc_a = a_valid && !reset && (ma_q.size() < DEPTH);
    acc_b = b_valid && !reset && (mb_q.size() < DEPTH);
    if (reset) begin
      ma_q.delete();
      mb_q.delete();
      m_we = 1'b0; m_dr = '0; m_data = '0; m_prio_b = 1'b0;
    end else begin
      if (ma_q.size() > 0 && (mb_q.size() == 0 || !m_prio_b)) begin
        h = ma_q.pop_front(); m_we = 1'b1; {m_dr, m_data} = h; m_prio_b = 1'b1;
      end else if (mb_q.size() > 0) begin
        h = mb_q.pop_front(); m_we = 1'b1; {m_dr, m_data} = h; m_prio_b = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (acc_a) ma_q.push_back({a_dr, a_data});
      if (acc_b) mb_q.push_back({b_dr, b_data});
    end
  end

  function automatic logic [NREG-1:0] model_pending();
    logic [NREG-1:0] p;
    logic [W-1:0] e;
    p = '0;
    foreach (ma_q[i]) begin e = ma_q[i]; p[e[W-1:DATA_W]] = 1'b1; end
    foreach (mb_q[i]) begin e = mb_q[i]; p[e[W-1:DATA_W]] = 1'b1; end
    if (m_we) p[m_dr] = 1'b1;
    return p;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rf_we",   32'(rf_we),   32'(m_we));
      chk("rf_dr",   32'(rf_dr),   32'(m_dr));
      chk("rf_data", 32'(rf_data), 32'(m_data));
      chk("pending", 32'(pending), 32'(model_pending()));
      chk("busy",    32'(busy),    32'(ma_q.size() != 0 || mb_q.size() != 0 || m_we));
      chk("a_ready", 32'(a_ready), 32'(!reset && ma_q.size() < DEPTH));
      chk("b_ready", 32'(b_ready), 32'(!reset && mb_q.size() < DEPTH));
    end
  end

  // ---------------- RegFile image driven by the DUT port ----------------
  logic [DATA_W-1:0] dut_rf [NREG];
  int                dut_wcnt [NREG];
  int                base [NREG];

  always @(posedge clk) begin
    if (rf_we === 1'b1) begin
      dut_rf[rf_dr] = rf_data;
      dut_wcnt[rf_dr] = dut_wcnt[rf_dr] + 1;
    end
  end

  task automatic snap();
    for (int r = 0; r < NREG; r++) base[r] = dut_wcnt[r];
  endtask

  // ---------------- retire scoreboard for the streaming test ----------------
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  int           n_ret = 0;
  logic         last_src_b = 1'b0;

  always @(negedge clk) begin
    if (log_en && rf_we === 1'b1) begin : sb
      logic src_b;
      logic [W-1:0] e;
      src_b = (rf_data[15:12] == 4'hB);
      if (n_ret > 0) chk("t3_alternate", 32'(src_b), 32'(!last_src_b));
      else           chk("t3_first_src", 32'(src_b), 32'(0));
      if (src_b) begin
        if (exp_b_q.size() == 0) chk("t3_b_extra", 32'(1), 32'(0));
        else begin e = exp_b_q.pop_front(); chk("t3_b_order", 32'({rf_dr, rf_data}), 32'(e)); end
      end else begin
        if (exp_a_q.size() == 0) chk("t3_a_extra", 32'(1), 32'(0));
        else begin e = exp_a_q.pop_front(); chk("t3_a_order", 32'({rf_dr, rf_data}), 32'(e)); end
      end
      last_src_b = src_b;
      n_ret++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_a(input logic v, input logic [ADDR_W-1:0] dr, input logic [DATA_W-1:0] d);
    a_valid = v; a_dr = dr; a_data = d;
  endtask

  task automatic set_b(input logic v, input logic [ADDR_W-1:0] dr, input logic [DATA_W-1:0] d);
    b_valid = v; b_dr = dr; b_data = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Leaves A full, B holding one entry and the B head (R2=0x5B01) on rf_*.
  task automatic prefill();
    set_a(1, 3'd1, 16'h5A01); set_b(1, 3'd2, 16'h5B01); tick();
    set_a(1, 3'd3, 16'h5A02); set_b(1, 3'd4, 16'h5B02); tick();
    set_a(1, 3'd5, 16'h5A03); set_b(0, 3'd0, 16'h0000); tick();
    set_a(0, 3'd0, 16'h0000);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int ia, ib, cyc, n;
    logic fa, fb, acc, saw_a_nr, saw_b_nr;

    tick(); tick();
    chk_en = 1'b1;
    chk("rst_rf_we",   32'(rf_we),   32'(0));
    chk("rst_rf_dr",   32'(rf_dr),   32'(0));
    chk("rst_pending", 32'(pending), 32'(0));
    chk("rst_busy",    32'(busy),    32'(0));
    chk("rst_a_ready", 32'(a_ready), 32'(0));
    reset = 1'b0;
    #1;
    chk("rst_rel_ready", 32'({a_ready, b_ready}), 32'(2'b11));

    // single write latency
    set_a(1, 3'd3, 16'h1234); tick(); set_a(0, 3'd0, 16'h0);
    chk("t1_we_e1",   32'(rf_we),      32'(0));
    chk("t1_pend_e1", 32'(pending[3]), 32'(1));
    tick();
    chk("t1_we",      32'(rf_we),   32'(1));
    chk("t1_dr",      32'(rf_dr),   32'(3));
    chk("t1_data",    32'(rf_data), 32'(16'h1234));
    chk("t1_pend",    32'(pending), 32'(8'h08));
    chk("t1_model_pend", 32'(model_pending()), 32'(8'h08));
    tick();
    chk("t1_we_off",  32'(rf_we),      32'(0));
    chk("t1_pend_off",32'(pending[3]), 32'(0));
    chk("t1_rf3",     32'(dut_rf[3]),  32'(16'h1234));
    chk("t1_model_we",32'(m_we),       32'(0));

    // simultaneous pairs, priority alternation
    do_reset();
    set_a(1, 3'd1, 16'h0011); set_b(1, 3'd2, 16'h0022); tick();
    set_a(1, 3'd1, 16'h0111); set_b(1, 3'd2, 16'h0222); tick();
    set_a(0, 3'd0, 16'h0); set_b(0, 3'd0, 16'h0);
    chk("t2_w1", 32'({rf_we, rf_dr, rf_data}), 32'({1'b1, 3'd1, 16'h0011})); tick();
    chk("t2_w2", 32'({rf_we, rf_dr, rf_data}), 32'({1'b1, 3'd2, 16'h0022})); tick();
    chk("t2_w3", 32'({rf_we, rf_dr, rf_data}), 32'({1'b1, 3'd1, 16'h0111})); tick();
    chk("t2_w4", 32'({rf_we, rf_dr, rf_data}), 32'({1'b1, 3'd2, 16'h0222})); tick();
    chk("t2_idle", 32'(rf_we), 32'(0));

    // both sources streaming 8 entries each
    do_reset();
    ia = 0; ib = 0; cyc = 0; saw_a_nr = 0; saw_b_nr = 0; n_ret = 0; log_en = 1'b1;
    while ((ia < 8 || ib < 8) && cyc < 100) begin
      set_a(ia < 8, 3'(ia % 4),     16'hA000 + 16'(ia));
      set_b(ib < 8, 3'(4 + ib % 4), 16'hB000 + 16'(ib));
      @(negedge clk);
      fa = a_valid && a_ready;
      fb = b_valid && b_ready;
      if (!a_ready) saw_a_nr = 1'b1;
      if (!b_ready) saw_b_nr = 1'b1;
      if (fa) exp_a_q.push_back({a_dr, a_data});
      if (fb) exp_b_q.push_back({b_dr, b_data});
      @(posedge clk); #1;
      if (fa) ia++;
      if (fb) ib++;
      cyc++;
    end
    set_a(0, 3'd0, 16'h0); set_b(0, 3'd0, 16'h0);
    chk("t3_pushed", 32'({8'(ia), 8'(ib)}), 32'({8'd8, 8'd8}));
    cyc = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0 || busy) && cyc < 60) begin
      tick(); cyc++;
    end
    log_en = 1'b0;
    chk("t3_retired", 32'(n_ret), 32'(16));
    chk("t3_left", 32'(exp_a_q.size() + exp_b_q.size()), 32'(0));
    chk("t3_a_backpressure", 32'(saw_a_nr), 32'(1));
    chk("t3_b_backpressure", 32'(saw_b_nr), 32'(1));

    // same register from both sources
    do_reset();
    set_a(1, 3'd5, 16'hAAAA); set_b(1, 3'd5, 16'hBBBB); tick();
    set_a(0, 3'd0, 16'h0); set_b(0, 3'd0, 16'h0);
    chk("t4_pend_q", 32'(pending), 32'(8'h20)); tick();
    chk("t4_w1", 32'({rf_we, rf_dr, rf_data, pending[5]}), 32'({1'b1, 3'd5, 16'hAAAA, 1'b1})); tick();
    chk("t4_w2", 32'({rf_we, rf_dr, rf_data, pending[5]}), 32'({1'b1, 3'd5, 16'hBBBB, 1'b1})); tick();
    chk("t4_done", 32'({rf_we, pending[5]}), 32'(0));
    chk("t4_r5", 32'(dut_rf[5]), 32'(16'hBBBB));

    // reset with both queues loaded
    do_reset();
    snap();
    prefill();
    chk("t5_inflight", 32'({rf_we, rf_dr, rf_data}), 32'({1'b1, 3'd2, 16'h5B01}));
    chk("t5_a_full", 32'(a_ready), 32'(0));
    reset = 1'b1; set_a(1, 3'd6, 16'h6666);
    #1;
    chk("t5_ready_in_rst", 32'({a_ready, b_ready}), 32'(0));
    tick();
    reset = 1'b0; set_a(0, 3'd0, 16'h0);
    #1;
    chk("t5_post_we",   32'(rf_we),   32'(0));
    chk("t5_post_pend", 32'(pending), 32'(0));
    chk("t5_post_busy", 32'(busy),    32'(0));
    chk("t5_post_rdy",  32'({a_ready, b_ready}), 32'(2'b11));
    repeat (6) tick();
    chk("t5_r2_commit", 32'(dut_rf[2]), 32'(16'h5B01));
    chk("t5_w_r1", 32'(dut_wcnt[1] - base[1]), 32'(1));
    chk("t5_w_r2", 32'(dut_wcnt[2] - base[2]), 32'(1));
    for (int r = 3; r <= 6; r++) chk("t5_no_write", 32'(dut_wcnt[r] - base[r]), 32'(0));

    // held request under backpressure
    do_reset();
    snap();
    prefill();
    set_a(1, 3'd7, 16'hBEEF);
    chk("t6_blocked", 32'(a_ready), 32'(0));
    n = 0; acc = 1'b0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = a_ready;
      n++;
      @(posedge clk); #1;
    end
    set_a(0, 3'd0, 16'h0);
    chk("t6_accepted", 32'(acc), 32'(1));
    chk("t6_wait", 32'(n), 32'(2));
    repeat (10) tick();
    chk("t6_r7_once", 32'(dut_wcnt[7] - base[7]), 32'(1));
    chk("t6_r7", 32'(dut_rf[7]), 32'(16'hBEEF));
    chk("t6_idle", 32'(busy), 32'(0));

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
